// File: rtl/bfly_addsub_pipe.sv
// bfly_addsub_pipe: two-stage elastic radix-2 butterfly (a+b, a-b) tagged with frame index/last.
// Define BFLY_SAT_EN to saturate results to WIDTH bits with a sticky ovf flag.
module bfly_addsub_pipe #(
  parameter int WIDTH = 10,
  parameter int FRAME_LEN = 8,
  localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1,
`ifdef BFLY_SAT_EN
  localparam int OW = WIDTH
`else
  localparam int OW = WIDTH + 1
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] out_sum,
  output logic signed [OW-1:0] out_diff,
  output logic [IW-1:0]        out_idx,
  output logic                 out_last,
  output logic                 ovf
);
  localparam logic [IW-1:0] LAST = IW'(FRAME_LEN - 1);
  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s1_load, s2_load, last_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH:0] sum_x, diff_x;
  logic [OW-1:0] sum_q, diff_q, sum_d, diff_d;
  logic [IW-1:0] cnt_q, cnt_d, idx_q;
`ifdef BFLY_SAT_EN
  logic sat_s, sat_d, ovf_q;
`endif
  always_comb begin
    s2_load = s1_valid_q && (!s2_valid_q || out_ready);
    in_ready = !s1_valid_q || s2_load;
    s1_load = in_valid && in_ready;
    s1_valid_d = s1_load ? 1'b1 : (s2_load ? 1'b0 : s1_valid_q);
    s2_valid_d = s2_load ? 1'b1 : (out_ready ? 1'b0 : s2_valid_q);
    cnt_d = s2_load ? ((cnt_q == LAST) ? '0 : cnt_q + 1'b1) : cnt_q;
    sum_x = {a_q[WIDTH-1], a_q} + {b_q[WIDTH-1], b_q};
    diff_x = {a_q[WIDTH-1], a_q} - {b_q[WIDTH-1], b_q};
`ifdef BFLY_SAT_EN
    // top two bits disagree exactly when the exact result leaves the WIDTH-bit range
    sat_s = sum_x[WIDTH] != sum_x[WIDTH-1];
    sat_d = diff_x[WIDTH] != diff_x[WIDTH-1];
    sum_d = sat_s ? {sum_x[WIDTH], {(WIDTH-1){~sum_x[WIDTH]}}} : sum_x[WIDTH-1:0];
    diff_d = sat_d ? {diff_x[WIDTH], {(WIDTH-1){~diff_x[WIDTH]}}} : diff_x[WIDTH-1:0];
`else
    sum_d = sum_x;
    diff_d = diff_x;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      diff_q <= '0;
      idx_q <= '0;
      last_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      cnt_q <= cnt_d;
      if (s1_load) begin
        a_q <= in_a;
        b_q <= in_b;
      end
      if (s2_load) begin
        sum_q <= sum_d;
        diff_q <= diff_d;
        idx_q <= cnt_q;
        last_q <= cnt_q == LAST;
      end
    end
  end
`ifdef BFLY_SAT_EN
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else if (s2_load && (sat_s || sat_d)) ovf_q <= 1'b1;
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif
  assign out_valid = s2_valid_q;
  assign out_sum = sum_q;
  assign out_diff = diff_q;
  assign out_idx = idx_q;
  assign out_last = last_q;
endmodule
